fsm: RTL and testbench
======================

FSM -- requirements
Module: fsm

Interface
REQ-001 Parameters (name, default, meaning):
- R_MIN, 8'd128: minimum red for a match.
- G_MAX, 8'd64: maximum green for a match.
- B_MAX, 8'd64: maximum blue for a match.
- CW, 12: width of the x/y pixel counters.
- MIN_PIXELS, 16: match-count threshold (see REQ-019).
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: rising-edge clock; one pixel per cycle.
- rst, in, 1: asynchronous, active-high reset.
- pixel_in, in, 25: [23:16]=R, [15:8]=G, [7:0]=B; bit 24 ignored.
- sof, in, 1: start of frame; the current pixel is pixel (0,0).
- eol_ext, in, 1: the current pixel is the last pixel of its line.
- x_out, out, 25: bounding-box centre x of the last completed frame, zero-extended.
- y_out, out, 25: bounding-box centre y of the last completed frame, zero-extended.
- found_out, out, 1: last completed frame contained a valid block.
- frame_done, out, 1: one-cycle pulse when results update.

Function
REQ-003 The FSM has two states, WAIT_SOF and SCAN; reset enters WAIT_SOF.
REQ-004 WAIT_SOF: pixels and eol_ext are ignored; sof=1 moves the FSM to SCAN, with the current pixel processed as (0,0).
REQ-005 SCAN: every cycle is one pixel at (xcnt,ycnt); after each pixel xcnt increments.
REQ-006 eol_ext=1 in SCAN: the current pixel is processed at its coordinate, then xcnt<=0 and ycnt<=ycnt+1.
REQ-007 xcnt and ycnt saturate at 2^CW-1 and do not wrap.
REQ-008 Match rule, evaluated combinationally on the current pixel: R>=R_MIN and G<=G_MAX and B<=B_MAX.
REQ-009 On a match, the block updates the per-frame xmin/xmax/ymin/ymax with the pixel coordinate and increments a CW*2-bit saturating match count.
REQ-010 sof=1 in SCAN ends the previous frame. In that same edge, the block:
- latches results;
- pulses frame_done the next cycle;
- clears the bbox/count;
- sets the current pixel to (0,0) of the new frame and evaluates it in the new frame.
REQ-011 Results on frame end:
- x_out = (xmin+xmax)>>1 and y_out = (ymin+ymax)>>1, with the sum computed at CW+1 bits;
- found_out=1 if at least one match occurred.
REQ-012 A frame with no matches sets found_out=0; x_out and y_out hold their prior values.
REQ-013 sof and eol_ext asserted together: sof takes precedence for the frame start, and the pixel is (0,0); eol_ext then applies, so the next pixel is (0,1).
REQ-014 Outputs are registered and change only on the edge that samples sof in SCAN.
REQ-015 Latency: results are visible one cycle after the sof edge.
REQ-016 Bbox registers reset to min=all-ones and max=0; these are also the values after each clear.

Reset
REQ-017 While rst=1, regardless of clk:
- x_out=0, y_out=0, found_out=0, frame_done=0;
- xcnt=0, ycnt=0, match count=0;
- bbox registers set as in REQ-016;
- state=WAIT_SOF.
REQ-018 Reset mid-frame discards the partial frame; after release the FSM waits for a new sof.

Configuration
REQ-019 With macro FSM_MIN_AREA_EN defined, found_out=1 only if match count >= MIN_PIXELS; otherwise x_out and y_out hold and found_out=0.
REQ-020 Without FSM_MIN_AREA_EN, any match count >=1 qualifies, and the match count logic is omitted.

Verification
REQ-021 The bench shall cover:
- Black frame: pixel_in=0, sof every 101 cycles, eol_ext 11 cycles after sof -> found_out=0, x_out=y_out=0, frame_done pulses once per sof after the first.
- Single red pixel 25'h0FF0000 at (5,0), macro off -> next sof: x_out=5, y_out=0, found_out=1.
- Red pixels at (2,1) and (8,3), macro off -> x_out=5, y_out=2.
- Same two pixels, FSM_MIN_AREA_EN, MIN_PIXELS=16 -> found_out=0, x_out/y_out unchanged.
- sof and eol_ext together with a red pixel on the following cycle -> that pixel registered at (0,1).
- rst=1 mid-frame after matches, then a new frame with no matches -> all outputs 0, found_out=0.

Source files
------------

// File: rtl/fsm.sv
// Colour-blob tracker: scans pixels and reports the bounding-box centre of matching pixels per frame.
// Optional macro FSM_MIN_AREA_EN: report a block only once the match count reaches MIN_PIXELS.
module fsm #(
   parameter logic [7:0] R_MIN      = 8'd128,
   parameter logic [7:0] G_MAX      = 8'd64,
   parameter logic [7:0] B_MAX      = 8'd64,
   parameter int         CW         = 12,
   parameter int         MIN_PIXELS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [24:0] pixel_in,
   input  logic        sof,
   input  logic        eol_ext,
   output logic [24:0] x_out,
   output logic [24:0] y_out,
   output logic        found_out,
   output logic        frame_done
);

   typedef enum logic {WAIT_SOF = 1'b0, SCAN = 1'b1} state_t;

   localparam logic [CW-1:0] CMAX = '1;

   state_t        state_q, state_d;
   logic [CW-1:0] xcnt_q, xcnt_d, ycnt_q, ycnt_d;
   logic [CW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
   logic [CW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
   logic [CW-1:0] xres_q, xres_d, yres_q, yres_d;
   logic          found_q, found_d, done_q, done_d;

   logic          pix_valid, frame_end, is_match, hit_now, qualify;
   logic [CW-1:0] cur_x, cur_y;
   logic [CW:0]   sum_x, sum_y;

`ifdef FSM_MIN_AREA_EN
   localparam logic [2*CW-1:0] MIN_CNT = (2*CW)'(MIN_PIXELS);
   localparam logic [2*CW-1:0] CNT_MAX = '1;
   logic [2*CW-1:0] cnt_q, cnt_d, cnt_base;
`else
   logic hit_q, hit_d;
`endif

   logic unused_ok;
   assign unused_ok = ^{pixel_in[24], MIN_PIXELS[0], sum_x[0], sum_y[0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= WAIT_SOF;
         xcnt_q  <= '0;
         ycnt_q  <= '0;
         xmin_q  <= CMAX;
         xmax_q  <= '0;
         ymin_q  <= CMAX;
         ymax_q  <= '0;
         xres_q  <= '0;
         yres_q  <= '0;
         found_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef FSM_MIN_AREA_EN
         cnt_q   <= '0;
`else
         hit_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         xcnt_q  <= xcnt_d;
         ycnt_q  <= ycnt_d;
         xmin_q  <= xmin_d;
         xmax_q  <= xmax_d;
         ymin_q  <= ymin_d;
         ymax_q  <= ymax_d;
         xres_q  <= xres_d;
         yres_q  <= yres_d;
         found_q <= found_d;
         done_q  <= done_d;
`ifdef FSM_MIN_AREA_EN
         cnt_q   <= cnt_d;
`else
         hit_q   <= hit_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      if (sof) state_d = SCAN;
   end

   always_comb begin
      // A sof pixel is always (0,0) of the frame it starts, whatever the counters hold.
      pix_valid = (state_q == SCAN) || sof;
      frame_end = (state_q == SCAN) && sof;
      cur_x     = sof ? '0 : xcnt_q;
      cur_y     = sof ? '0 : ycnt_q;
      is_match  = (pixel_in[23:16] >= R_MIN) && (pixel_in[15:8] <= G_MAX) &&
                  (pixel_in[7:0] <= B_MAX);
      hit_now   = pix_valid && is_match;

      xcnt_d = xcnt_q;
      ycnt_d = ycnt_q;
      if (pix_valid) begin
         if (eol_ext) begin
            xcnt_d = '0;
            ycnt_d = (cur_y == CMAX) ? cur_y : cur_y + CW'(1);
         end else begin
            xcnt_d = (cur_x == CMAX) ? cur_x : cur_x + CW'(1);
            ycnt_d = cur_y;
         end
      end

      xmin_d = sof ? CMAX : xmin_q;
      xmax_d = sof ? '0   : xmax_q;
      ymin_d = sof ? CMAX : ymin_q;
      ymax_d = sof ? '0   : ymax_q;
      if (hit_now) begin
         if (cur_x < xmin_d) xmin_d = cur_x;
         if (cur_x > xmax_d) xmax_d = cur_x;
         if (cur_y < ymin_d) ymin_d = cur_y;
         if (cur_y > ymax_d) ymax_d = cur_y;
      end

`ifdef FSM_MIN_AREA_EN
      cnt_base = sof ? '0 : cnt_q;
      cnt_d    = (hit_now && (cnt_base != CNT_MAX)) ? cnt_base + (2*CW)'(1) : cnt_base;
      qualify  = (cnt_q >= MIN_CNT);
`else
      hit_d    = (sof ? 1'b0 : hit_q) | hit_now;
      qualify  = hit_q;
`endif

      // Results come from the bbox of the frame just closed, before this edge clears it.
      sum_x   = {1'b0, xmin_q} + {1'b0, xmax_q};
      sum_y   = {1'b0, ymin_q} + {1'b0, ymax_q};
      xres_d  = xres_q;
      yres_d  = yres_q;
      found_d = found_q;
      done_d  = frame_end;
      if (frame_end) begin
         found_d = qualify;
         if (qualify) begin
            xres_d = sum_x[CW:1];
            yres_d = sum_y[CW:1];
         end
      end
   end

   always_comb begin
      x_out      = {{(25-CW){1'b0}}, xres_q};
      y_out      = {{(25-CW){1'b0}}, yres_q};
      found_out  = found_q;
      frame_done = done_q;
   end

endmodule

// File: tb/tb_fsm.sv
// Bench for fsm: a queue-based frame model checked every cycle, plus hand-computed frame results.
// Expectations follow FSM_MIN_AREA_EN when the bench is built with it.
module tb_fsm;

   localparam int MAXC = 15;
   localparam logic [24:0] RED = 25'h0FF0000;
`ifdef FSM_MIN_AREA_EN
   localparam bit AREA = 1'b1;
`else
   localparam bit AREA = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [24:0] pixel_in = '0;
   logic        sof = 1'b0;
   logic        eol_ext = 1'b0;
   logic [24:0] x_out, y_out;
   logic        found_out, frame_done;

   fsm #(.CW(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .pixel_in   (pixel_in),
      .sof        (sof),
      .eol_ext    (eol_ext),
      .x_out      (x_out),
      .y_out      (y_out),
      .found_out  (found_out),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Model: collect coordinates of matching pixels, reduce to a bbox centre when the frame closes.
   int          hx[$], hy[$];
   int          px, py, mnx, mxx, mny, mxy;
   bit          in_frame, ok;
   logic [24:0] exp_x, exp_y;
   logic        exp_found, exp_done;

   function automatic bit is_red(input logic [24:0] p);
      return (p[23:16] >= 8'd128) && (p[15:8] <= 8'd64) && (p[7:0] <= 8'd64);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         in_frame = 0; px = 0; py = 0;
         hx.delete(); hy.delete();
         exp_x = '0; exp_y = '0; exp_found = 1'b0; exp_done = 1'b0;
      end else begin
         exp_done = 1'b0;
         if (sof) begin
            if (in_frame) begin
               exp_done = 1'b1;
               ok = AREA ? (hx.size() >= 16) : (hx.size() > 0);
               exp_found = ok;
               if (ok) begin
                  mnx = MAXC; mxx = 0; mny = MAXC; mxy = 0;
                  foreach (hx[i]) begin
                     if (hx[i] < mnx) mnx = hx[i];
                     if (hx[i] > mxx) mxx = hx[i];
                     if (hy[i] < mny) mny = hy[i];
                     if (hy[i] > mxy) mxy = hy[i];
                  end
                  exp_x = 25'((mnx + mxx) / 2);
                  exp_y = 25'((mny + mxy) / 2);
               end
            end
            hx.delete(); hy.delete();
            in_frame = 1; px = 0; py = 0;
         end
         if (in_frame) begin
            if (is_red(pixel_in)) begin
               hx.push_back(px);
               hy.push_back(py);
            end
            if (eol_ext) begin
               px = 0;
               py = (py < MAXC) ? py + 1 : MAXC;
            end else begin
               px = (px < MAXC) ? px + 1 : MAXC;
            end
         end
      end
   end

   int n_cmp = 0;
   int n_err = 0;
   int done_seen = 0;

   task automatic lit(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input logic [24:0] p, input logic s, input logic e);
      pixel_in = p; sof = s; eol_ext = e;
      @(posedge clk);
      #1;
   endtask

   task automatic check_res(input string tag, input int f, input int x, input int y);
      lit({tag, "_found"}, int'(found_out), f);
      lit({tag, "_x"}, int'(x_out), x);
      lit({tag, "_y"}, int'(y_out), y);
      lit({tag, "_done"}, int'(frame_done), 1);
   endtask

   // Frame body after its sof pixel: w x h raster, eol on the last column.
   task automatic body(input int w, input int h, input int rx0, input int ry0,
                       input int rx1, input int ry1, input bit all_red);
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            if (x == 0 && y == 0) continue;
            cyc((all_red || (x == rx0 && y == ry0) || (x == rx1 && y == ry1)) ? RED : 25'd0,
                1'b0, x == w - 1);
         end
      end
   endtask

   task automatic stimulus();
      int base;
      repeat (3) @(posedge clk);
      #1;
      lit("rst_x", int'(x_out), 0);
      lit("rst_y", int'(y_out), 0);
      lit("rst_found", int'(found_out), 0);
      lit("rst_done", int'(frame_done), 0);
      rst = 1'b0;
      repeat (3) cyc(RED, 1'b0, 1'b0);
      lit("idle_found", int'(found_out), 0);

      base = done_seen;
      for (int f = 0; f < 3; f++)
         for (int k = 0; k < 101; k++)
            cyc(25'd0, k == 0, (k > 0) && (k % 11 == 0));

      cyc(25'd0, 1'b1, 1'b0);
      check_res("black", 0, 0, 0);
      body(8, 2, 5, 0, -1, -1, 1'b0);
      lit("black_done_cnt", done_seen - base, 3);

      cyc(25'd0, 1'b1, 1'b0);
      check_res("single", AREA ? 0 : 1, AREA ? 0 : 5, 0);
      body(10, 4, 2, 1, 8, 3, 1'b0);

      cyc(25'd0, 1'b1, 1'b1);
      check_res("pair", AREA ? 0 : 1, AREA ? 0 : 5, AREA ? 0 : 2);
      cyc(RED, 1'b0, 1'b0);
      repeat (3) cyc(25'd0, 1'b0, 1'b0);

      cyc(RED, 1'b1, 1'b0);
      check_res("sof_eol", AREA ? 0 : 1, 0, AREA ? 0 : 1);
      body(5, 4, -1, -1, -1, -1, 1'b1);

      cyc(25'd0, 1'b1, 1'b0);
      check_res("area20", 1, 2, 1);
      body(20, 20, 19, 19, -1, -1, 1'b0);

      cyc(25'd0, 1'b1, 1'b0);
      check_res("sat", AREA ? 0 : 1, AREA ? 2 : 15, AREA ? 1 : 15);
      body(10, 4, 2, 1, 8, 3, 1'b0);

      cyc(25'd0, 1'b1, 1'b0);
      check_res("pair_hold", AREA ? 0 : 1, AREA ? 2 : 5, AREA ? 1 : 2);
      repeat (3) cyc(RED, 1'b0, 1'b0);
      rst = 1'b1;
      #2;
      lit("midrst_x", int'(x_out), 0);
      lit("midrst_y", int'(y_out), 0);
      lit("midrst_found", int'(found_out), 0);
      lit("midrst_done", int'(frame_done), 0);
      repeat (2) cyc(RED, 1'b0, 1'b0);
      rst = 1'b0;
      repeat (3) cyc(RED, 1'b0, 1'b0);
      lit("postrst_found", int'(found_out), 0);
      lit("postrst_done", int'(frame_done), 0);

      cyc(25'd0, 1'b1, 1'b0);
      lit("newframe_done", int'(frame_done), 0);
      body(4, 3, -1, -1, -1, -1, 1'b0);
      cyc(25'd0, 1'b1, 1'b0);
      check_res("after_rst", 0, 0, 0);
      repeat (3) cyc(25'd0, 1'b0, 1'b0);
   endtask

   initial begin
      fork
         stimulus();
         forever begin
            @(negedge clk);
            if (frame_done === 1'b1) done_seen++;
            n_cmp++;
            if ({x_out, y_out, found_out, frame_done} !== {exp_x, exp_y, exp_found, exp_done}) begin
               n_err++;
               $display("FAIL cycle_cmp t=%0t: got x=%0d y=%0d found=%0b done=%0b, expected x=%0d y=%0d found=%0b done=%0b",
                        $time, x_out, y_out, found_out, frame_done,
                        exp_x, exp_y, exp_found, exp_done);
            end
         end
      join_any
      disable fork;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
